obi_wrr_sched: RTL

- Weighted round-robin scheduler for one shared OBI manager port contended by NumReq requesters.
- Picks which requester drives the shared request channel and holds that choice until the downstream grant.
- Limits in-flight transactions and records the issue order. Response steering can then use the head index, since OBI responses return in order.
- Drives the select lines of a plain request/response mux and replaces a fixed round-robin arbiter where bandwidth shares are required.

---
 rtl/obi_wrr_sched.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/obi_wrr_sched.sv
// Weighted round-robin scheduler for a shared OBI manager port.
// Chooses one requester, holds the choice until the downstream grant and
// records the issue order so in-order responses can be steered to their owner.
module obi_wrr_sched #(
  parameter  int unsigned NumReq      = 4,
  parameter  int unsigned WeightWidth = 4,
  parameter  int unsigned NumMaxTrans = 4,
  localparam int unsigned IdxWidth    = $clog2(NumReq),
  localparam int unsigned CntWidth    = $clog2(NumMaxTrans + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq*WeightWidth-1:0] weights_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [IdxWidth-1:0]           sel_idx_o,
  output logic                          mst_req_o,
  input  logic                          mst_gnt_i,
  input  logic                          rsp_valid_i,
  input  logic                          rsp_ready_i,
  output logic [IdxWidth-1:0]           rsp_idx_o,
  output logic                          rsp_idx_valid_o,
  output logic [CntWidth-1:0]           outstanding_o,
  output logic                          err_o
);

  localparam int unsigned PtrWidth = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(NumMaxTrans - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                 state_reg;
  logic [IdxWidth-1:0]    lock_idx_reg;
  logic [IdxWidth-1:0]    ptr_reg;
  logic [WeightWidth-1:0] burst_cnt_reg;
  logic [WeightWidth-1:0] burst_cnt_next;
  logic [IdxWidth-1:0]    sel_hold_reg;
  logic                   err_reg;

  logic [IdxWidth-1:0]    fifo_mem [NumMaxTrans];
  logic [PtrWidth-1:0]    wr_ptr_reg;
  logic [PtrWidth-1:0]    rd_ptr_reg;
  logic [CntWidth-1:0]    count_reg;

  logic [WeightWidth-1:0] weight_eff [NumReq];
  logic                   cand_found;
  logic [IdxWidth-1:0]    cand_idx;
  logic [IdxWidth-1:0]    scan_idx;
  logic                   continue_burst;
  logic [WeightWidth-1:0] burst_base;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   rsp_hs;
  logic                   pop;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrWidth'(1);
  endfunction

  // A zero weight still grants one transaction per turn.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_weight
    assign weight_eff[gi] = (weights_i[gi*WeightWidth +: WeightWidth] == '0)
                          ? WeightWidth'(1)
                          : weights_i[gi*WeightWidth +: WeightWidth];
  end

  assign full   = (count_reg == CntWidth'(NumMaxTrans));
  assign empty  = (count_reg == '0);
  assign rsp_hs = rsp_valid_i && rsp_ready_i;
  assign pop    = rsp_hs && !empty;

  // Candidate selection: a pending lock wins, then the burst owner, then a
  // wrapping scan starting after ptr with ptr itself as the last candidate.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    scan_idx   = '0;
    if (state_reg == LOCKED && req_i[lock_idx_reg]) begin
      cand_found = 1'b1;
      cand_idx   = lock_idx_reg;
    end else if (req_i[ptr_reg] && burst_cnt_reg != '0) begin
      cand_found = 1'b1;
      cand_idx   = ptr_reg;
    end else begin
      for (int k = 1; k <= int'(NumReq); k++) begin
        scan_idx = IdxWidth'((32'(ptr_reg) + 32'(k)) % NumReq);
        if (!cand_found && req_i[scan_idx]) begin
          cand_found = 1'b1;
          cand_idx   = scan_idx;
        end
      end
    end
  end

  assign mst_req_o = cand_found && !full;
  assign accept    = mst_req_o && mst_gnt_i;
  assign sel_idx_o = cand_found ? cand_idx : sel_hold_reg;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
    assign gnt_o[gi] = accept && (cand_idx == IdxWidth'(gi));
  end

  // Ptr and burst state are frozen while locked, so re-deriving "continue vs
  // reload" at grant time gives the same answer as when the lock was taken.
  assign continue_burst = (cand_idx == ptr_reg) && (burst_cnt_reg != '0);
  assign burst_base     = continue_burst ? burst_cnt_reg : weight_eff[cand_idx];
  assign burst_cnt_next = burst_base - WeightWidth'(1);

  // Scheduler state: lock FSM, round-robin pointer, burst counter, sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      lock_idx_reg  <= '0;
      ptr_reg       <= '0;
      burst_cnt_reg <= '0;
      sel_hold_reg  <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (cand_found) sel_hold_reg <= cand_idx;
      if (accept) begin
        ptr_reg       <= cand_idx;
        burst_cnt_reg <= burst_cnt_next;
      end
      if (rsp_hs && empty) err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (mst_req_o && !mst_gnt_i) begin
            state_reg    <= LOCKED;
            lock_idx_reg <= cand_idx;
          end
        end
        LOCKED: begin
          if (!req_i[lock_idx_reg]) begin
            // Locked requester withdrew: fall back to the idle choice.
            if (mst_req_o && !mst_gnt_i) lock_idx_reg <= cand_idx;
            else                         state_reg    <= IDLE;
          end else if (accept) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Issue-order FIFO storage; reset only clears the pointers.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_mem[wr_ptr_reg] <= cand_idx;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + CntWidth'(1);
        2'b01:   count_reg <= count_reg - CntWidth'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rsp_idx_valid_o = !empty;
  assign rsp_idx_o       = empty ? '0 : fifo_mem[rd_ptr_reg];
  assign outstanding_o   = count_reg;
  assign err_o           = err_reg;

endmodule
